// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
//   Read-side consumer of async_fifo. It pops words from the FIFO read port
//   into a 2-entry registered skid buffer. The words leave the buffer as a
//   valid/ready stream.
//   rinc is built only from the registered occupancy and rempty, so the sink's
//   m_ready never reaches the FIFO pop strobe combinationally.
//   Optional feature: define ASYNC_FIFO_RD_CNT_EN to add the rd_count port,
//   which counts the words delivered on the stream (wraps at 2^CSIZE).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_EMPTY | no word buffered; m_valid=0; pops whenever rempty=0
//   ST_ONE   | one word buffered; pop and accept may overlap (1 word/cycle)
//   ST_FULL  | both entries hold words; rinc held low until an accept
module async_fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef ASYNC_FIFO_RD_CNT_EN
  ,
  output logic [CSIZE-1:0] rd_count
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic             wp;
  logic             rp;
  logic [DSIZE-1:0] buf_mem [0:1];
  logic             pop;
  logic             acc;

  // rrst_n gates the pop so that the FIFO is never drained while both sides are held in reset
  assign rinc    = rrst_n && !rempty && (occ != ST_FULL);
  assign m_valid = (occ != ST_EMPTY);
  assign m_data  = buf_mem[rp];
  assign pop     = rinc;
  assign acc     = m_valid && m_ready;

  // Occupancy next-state: +1 on pop only, -1 on accept only, hold on both
  always_comb begin
    occ_nxt = occ;
    case (occ)
      ST_EMPTY: if (pop) occ_nxt = ST_ONE;
      ST_ONE: begin
        if (pop && !acc)      occ_nxt = ST_FULL;
        else if (acc && !pop) occ_nxt = ST_EMPTY;
      end
      ST_FULL:  if (acc) occ_nxt = ST_ONE;
      default:  occ_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy and buffer pointers
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ <= ST_EMPTY;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      occ <= occ_nxt;
      if (pop) wp <= ~wp;
      if (acc) rp <= ~rp;
    end
  end

  // Buffer storage, cleared so m_data reads zero out of reset
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else if (pop) begin
      buf_mem[wp] <= rdata;
    end
  end

`ifdef ASYNC_FIFO_RD_CNT_EN
  // Delivered-word counter, wraps naturally at 2^CSIZE
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)  rd_count <= '0;
    else if (acc) rd_count <= rd_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Testbench for async_fifo_rd_stream. The bench plays the async_fifo: its
// FIFO contents are kept in a queue. It also plays the stream sink. A
// reference model tracks the words that have been popped but not yet
// accepted, and predicts rinc, m_valid and m_data every cycle.
module tb_async_fifo_rd_stream;

  localparam int DSIZE = 8;
`ifdef ASYNC_FIFO_RD_CNT_EN
  localparam int CSIZE = 4;
`else
  localparam int CSIZE = 16;
`endif

  logic             rclk;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
`ifdef ASYNC_FIFO_RD_CNT_EN
  logic [CSIZE-1:0] rd_count;
`endif

  async_fifo_rd_stream #(.DSIZE(DSIZE), .CSIZE(CSIZE)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef ASYNC_FIFO_RD_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int acc_total = 0;

  logic [DSIZE-1:0] fifo_q [$];
  logic [DSIZE-1:0] infl_q [$];
  logic [DSIZE-1:0] sink_q [$];
  logic             hide;

  logic             s_rinc, s_valid, s_rempty;
  logic [DSIZE-1:0] s_data;
  logic             e_rinc, e_valid;
  logic [DSIZE-1:0] e_data;

  // One clock cycle: drive FIFO side, predict, sample at negedge, update model at posedge
  task automatic tick();
    rempty = hide || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    e_rinc  = rrst_n && !rempty && (infl_q.size() < 2);
    e_valid = (infl_q.size() > 0);
    e_data  = e_valid ? infl_q[0] : '0;
    @(negedge rclk);
    s_rinc   = rinc;
    s_valid  = m_valid;
    s_data   = m_data;
    s_rempty = rempty;
    @(posedge rclk);
    if (s_valid === 1'b1 && m_ready === 1'b1) begin
      sink_q.push_back(s_data);
      if (infl_q.size() > 0) void'(infl_q.pop_front());
      acc_total++;
    end
    if (s_rinc === 1'b1 && fifo_q.size() > 0) infl_q.push_back(fifo_q.pop_front());
    #1;
  endtask

  task automatic test_reset();
    rrst_n  = 1'b0;
    rempty  = 1'b0;
    rdata   = 8'hAA;
    m_ready = 1'b1;
    hide    = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    checks++;
    if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", rinc); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
    rempty = 1'b1;
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  task automatic test_single();
    sink_q.delete();
    m_ready = 1'b1;
    fifo_q.push_back(8'h5A);
    tick();
    checks++;
    if (s_rinc !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", s_rinc); end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'h5A)
      begin errors++; $display("FAIL single_out got v=%b d=%h want v=1 d=5a", s_valid, s_data); end
    checks++;
    if (s_rinc !== 1'b0) begin errors++; $display("FAIL single_nopop got %b want 0", s_rinc); end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", s_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    sink_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DSIZE'(i));
    repeat (4) tick();
    checks++;
    if (s_rinc !== 1'b0 || s_valid !== 1'b1 || s_data !== 8'h01)
      begin errors++; $display("FAIL bp_full got rinc=%b v=%b d=%h want rinc=0 v=1 d=01", s_rinc, s_valid, s_data); end
    checks++;
    if (fifo_q.size() != 2) begin errors++; $display("FAIL bp_pops got %0d left want 2", fifo_q.size()); end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && sink_q.size() < 4; c++) begin
      tick();
      checks++;
      if (s_valid !== e_valid || (e_valid && s_data !== e_data))
        begin errors++; $display("FAIL bp_drain got v=%b d=%h want v=%b d=%h", s_valid, s_data, e_valid, e_data); end
    end
    ok = (sink_q.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (sink_q[i] !== DSIZE'(i + 1)) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_order got %0d words, want 01..04 in order", sink_q.size()); end
  endtask

  task automatic test_streaming();
    int first_rinc, first_v, last_v, nv;
    bit ok;
    sink_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) fifo_q.push_back(DSIZE'(i));
    first_rinc = -1; first_v = -1; last_v = -1; nv = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_rinc === 1'b1 && first_rinc < 0) first_rinc = c;
      if (s_valid === 1'b1) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
    end
    checks++;
    if (first_v != first_rinc + 1 || nv != 16 || last_v - first_v != 15)
      begin errors++; $display("FAIL stream_valid got first=%0d n=%0d span=%0d want first=%0d n=16 span=15", first_v, nv, last_v - first_v, first_rinc + 1); end
    ok = (sink_q.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (sink_q[i] !== DSIZE'(i)) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_order got %0d words want 00..0f", sink_q.size()); end
  endtask

  task automatic test_random();
    logic [DSIZE-1:0] src [$];
    int bad;
    sink_q.delete();
    for (int i = 0; i < 1000; i++) begin
      src.push_back(DSIZE'($urandom));
      fifo_q.push_back(src[i]);
    end
    for (int c = 0; c < 10000 && sink_q.size() < 1000; c++) begin
      hide    = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (s_rinc === 1'b1 && s_rempty === 1'b1)
        begin errors++; $display("FAIL rand_rinc_empty got rinc=1 want 0 while rempty=1"); end
      checks++;
      if (s_rinc !== e_rinc || s_valid !== e_valid || (e_valid && s_data !== e_data))
        begin errors++; $display("FAIL rand_cycle got rinc=%b v=%b d=%h want rinc=%b v=%b d=%h", s_rinc, s_valid, s_data, e_rinc, e_valid, e_data); end
    end
    hide = 1'b0;
    bad = 0;
    if (sink_q.size() != 1000) bad = 1;
    for (int i = 0; i < 1000 && bad == 0; i++) if (sink_q[i] !== src[i]) bad = 1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_order got %0d words, want 1000 in source order", sink_q.size()); end
  endtask

  task automatic test_midop_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'hC0 + DSIZE'(i));
    repeat (3) tick();
    checks++;
    if (s_valid !== 1'b1 || infl_q.size() != 2)
      begin errors++; $display("FAIL mid_fill got v=%b buffered=%0d want v=1 buffered=2", s_valid, infl_q.size()); end
    rrst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || rinc !== 1'b0 || m_data !== 8'h00)
      begin errors++; $display("FAIL mid_reset got v=%b rinc=%b d=%h want v=0 rinc=0 d=00", m_valid, rinc, m_data); end
    fifo_q.delete();
    infl_q.delete();
    acc_total = 0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_rinc !== 1'b0)
      begin errors++; $display("FAIL mid_after got v=%b rinc=%b want 0 0", s_valid, s_rinc); end
  endtask

`ifdef ASYNC_FIFO_RD_CNT_EN
  task automatic test_count();
    sink_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) fifo_q.push_back(DSIZE'($urandom));
    for (int c = 0; c < 60 && sink_q.size() < 17; c++) tick();
    checks++;
    if (rd_count !== CSIZE'(acc_total % (1 << CSIZE)) || acc_total != 17)
      begin errors++; $display("FAIL count_wrap got %0d (accepts %0d) want 1 after 17", rd_count, acc_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_random();
    test_midop_reset();
`ifdef ASYNC_FIFO_RD_CNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
